ring_shift_seq: RTL and testbench
=================================

Name: ring_shift_seq

Overview:
Parametrised ring/pattern shift sequencer for LED chaser and display-scan use. It is the multi-mode successor of the fixed 4-bit rotate register. It adds:
- a built-in step prescaler
- selectable mode: rotate right, rotate left, bounce, fill
- step and wrap strobes for downstream logic

It sits between the board clock and the LED or scan output pins.

Parameters:
WIDTH, 8, pattern width in bits (>=2)
DIV_WIDTH, 24, prescaler counter and div port width
INIT, 1, reset pattern (WIDTH bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  step enable; 0 freezes prescaler and pattern
div  in  DIV_WIDTH  step period minus 1, in enabled clk cycles
mode  in  2  00 rotate right, 01 rotate left, 10 bounce, 11 fill
pat  out  WIDTH  current pattern (registered)
step  out  1  one-cycle pulse aligned with each new pat value
wrap  out  1  one-cycle pulse aligned with the pat value completing a sequence period

Behaviour:
- Reset: rst=1 at a clk edge overrides everything. Result: pat=INIT, prescaler cnt=0, pos=0, dir=left, step=0, wrap=0. A reset mid-count discards partial counts.
- Prescaler, when en=1:
  - if cnt>=div: cnt<=0 and internal tick=1
  - else: cnt<=cnt+1
  - div=0 gives a tick every enabled cycle. The >= compare makes a reduced div take effect immediately.
- en=0: cnt, pat, pos and dir hold; step=0, wrap=0.
- On tick, pat updates at that edge. step and wrap are registered, so they are high in the same cycle the new pat appears. Without a tick, step=0 and wrap=0.
- Rotate right (00): pat <= {pat[0], pat[W-1:1]}.
- Rotate left (01): pat <= {pat[W-2:0], pat[W-1]}.
- Rotate step counting:
  - pos counts steps 0..W-1.
  - The step taking pos from W-1 to 0 asserts wrap, so wrap fires every W steps.
  - An all-zero pattern stays zero, but wrap still fires.
- Bounce (10): zero-fill shift in direction dir.
  - dir=left and pat[W-1]=1: dir<=right and shift right this step.
  - dir=right and pat[0]=1: dir<=left, shift left this step, and assert wrap.
  - Otherwise shift in dir.
  - Period is 2(W-1) steps for a one-hot pattern.
  - All-zero stays zero with no wrap.
- Fill (11):
  - pat <= {pat[W-2:0], 1'b1}.
  - If pat is all ones, pat <= 1 and wrap is asserted.
- Mode change: mode is registered as mode_q. Any cycle with mode!=mode_q clears pos and sets dir=left. pat is kept, and the new mode applies from the next tick. A tick in the same cycle uses the new mode with pos=0.

Optional Feature:
SHIFT_LOAD_EN
- Defined: adds ports load (in, 1) and load_val (in, WIDTH).
  - load=1 ranks below rst and above everything else, and acts regardless of en.
  - It sets pat<=load_val, cnt<=0, pos<=0, dir=left, and step=0, wrap=0 that cycle.
  - A tick coinciding with load is discarded.
- Undefined: the ports do not exist, and pat changes only via rst or tick.

Test Plan:
1. WIDTH=4, INIT=0001, mode=00, div=0, en=1 after rst -> pat 1000, 0100, 0010, 0001 on consecutive cycles; step high each cycle; wrap only with the 0001.
2. mode=01, div=2 -> pat 0001->0010->0100 every 3 cycles. Then en=0 for 5 cycles -> pat and phase frozen, step=0; on resume the next step lands at the remaining count.
3. mode=10 from 0001 -> 0010, 0100, 1000, 0100, 0010, 0001, 0010. wrap only with the final 0010; 0001->0010 reversal confirmed.
4. mode=11 from 0001 -> 0011, 0111, 1111, 0001. wrap with 0001; the sequence repeats.
5. div=5, rst pulsed at cnt=3 -> next cycle pat=INIT, step=0. First step occurs on the 6th enabled cycle after rst deasserts.
6. SHIFT_LOAD_EN, mode=00: load=1, load_val=1010 on the tick cycle -> pat=1010, step=0. The next tick, div+1 cycles later, gives pat=0101.

Source files
------------

// File: rtl/ring_shift_seq.sv
// Multi-mode ring/pattern shift sequencer (rotate right/left, bounce, fill) with step prescaler.
// Optional macro SHIFT_LOAD_EN adds a synchronous parallel load (load, load_val).
module ring_shift_seq #(
  parameter int              WIDTH     = 8,
  parameter int              DIV_WIDTH = 24,
  parameter logic [WIDTH-1:0] INIT     = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [1:0]           mode,
`ifdef SHIFT_LOAD_EN
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
`endif
  output logic [WIDTH-1:0]     pat,
  output logic                 step,
  output logic                 wrap
);

  localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] MODE_ROR    = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic [0:0] DIR_LEFT  = 1'b0;
  localparam logic [0:0] DIR_RIGHT = 1'b1;

  localparam logic [PW-1:0]        POS_LAST = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] cnt_nxt_s;
  logic [PW-1:0]        pos_r;
  logic [PW-1:0]        pos_eff_s;
  logic [PW-1:0]        pos_nxt_s;
  logic [0:0]           dir_r;
  logic [0:0]           dir_eff_s;
  logic [0:0]           dir_nxt_s;
  logic [1:0]           mode_q_r;
  logic                 mode_chg_s;
  logic                 tick_s;
  logic [WIDTH-1:0]     pat_nxt_s;
  logic                 wrap_nxt_s;

  // Prescaler: the >= compare lets a reduced div take effect on the very next cycle.
  always_comb begin
    tick_s    = 1'b0;
    cnt_nxt_s = cnt_r;
    if (en) begin
      if (cnt_r >= div) begin
        tick_s    = 1'b1;
        cnt_nxt_s = {DIV_WIDTH{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      tick_s    = 1'b0;
      cnt_nxt_s = cnt_r;
    end
  end

  // Pattern next state; a mode change restarts pos/dir before any coincident tick uses them.
  always_comb begin
    mode_chg_s = (mode != mode_q_r);
    pos_eff_s  = mode_chg_s ? {PW{1'b0}} : pos_r;
    dir_eff_s  = mode_chg_s ? DIR_LEFT : dir_r;
    pat_nxt_s  = pat;
    pos_nxt_s  = pos_eff_s;
    dir_nxt_s  = dir_eff_s;
    wrap_nxt_s = 1'b0;
    if (tick_s) begin
      case (mode)
        MODE_ROR, MODE_ROL: begin
          pat_nxt_s = (mode == MODE_ROR) ? {pat[0], pat[WIDTH-1:1]}
                                         : {pat[WIDTH-2:0], pat[WIDTH-1]};
          if (pos_eff_s == POS_LAST) begin
            pos_nxt_s  = {PW{1'b0}};
            wrap_nxt_s = 1'b1;
          end else begin
            pos_nxt_s  = pos_eff_s + PW'(1);
          end
        end
        MODE_BOUNCE: begin
          if ((dir_eff_s == DIR_LEFT) && pat[WIDTH-1]) begin
            dir_nxt_s = DIR_RIGHT;
            pat_nxt_s = {1'b0, pat[WIDTH-1:1]};
          end else if ((dir_eff_s == DIR_RIGHT) && pat[0]) begin
            dir_nxt_s  = DIR_LEFT;
            pat_nxt_s  = {pat[WIDTH-2:0], 1'b0};
            wrap_nxt_s = 1'b1;
          end else if (dir_eff_s == DIR_LEFT) begin
            pat_nxt_s = {pat[WIDTH-2:0], 1'b0};
          end else begin
            pat_nxt_s = {1'b0, pat[WIDTH-1:1]};
          end
        end
        MODE_FILL: begin
          if (&pat) begin
            pat_nxt_s  = PAT_ONE;
            wrap_nxt_s = 1'b1;
          end else begin
            pat_nxt_s  = {pat[WIDTH-2:0], 1'b1};
          end
        end
        default: begin
          pat_nxt_s = pat;
        end
      endcase
    end else begin
      pat_nxt_s  = pat;
      wrap_nxt_s = 1'b0;
    end
  end

  // State and registered outputs; rst, then load (if built), then normal stepping.
  always_ff @(posedge clk) begin
    mode_q_r <= mode;
    if (rst) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
      pat   <= INIT;
      pos_r <= {PW{1'b0}};
      dir_r <= DIR_LEFT;
      step  <= 1'b0;
      wrap  <= 1'b0;
`ifdef SHIFT_LOAD_EN
    end else if (load) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
      pat   <= load_val;
      pos_r <= {PW{1'b0}};
      dir_r <= DIR_LEFT;
      step  <= 1'b0;
      wrap  <= 1'b0;
`endif
    end else begin
      cnt_r <= cnt_nxt_s;
      pat   <= pat_nxt_s;
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
      step  <= tick_s;
      wrap  <= wrap_nxt_s;
    end
  end

endmodule

// File: tb/tb_ring_shift_seq.sv
// Table-driven self-checking bench for ring_shift_seq (WIDTH=4, INIT=0001).
module tb_ring_shift_seq;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] div;
  logic [1:0]    mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  pat;
  logic          step;
  logic          wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          rst;
    logic          en;
    logic [DW-1:0] div;
    logic [1:0]    mode;
    logic [W-1:0]  exp_pat;
    logic          exp_step;
    logic          exp_wrap;
  } vec_t;

  vec_t vecs[$];

  ring_shift_seq #(.WIDTH(W), .DIV_WIDTH(DW), .INIT(4'b0001)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div(div),
    .mode(mode),
`ifdef SHIFT_LOAD_EN
    .load(load),
    .load_val(load_val),
`endif
    .pat(pat),
    .step(step),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [DW-1:0] d, input logic [1:0] m,
                     input logic [W-1:0] p, input logic s, input logic wr);
    vec_t v;
    v = '{rst: r, en: e, div: d, mode: m, exp_pat: p, exp_step: s, exp_wrap: wr};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_and_check(input string tag, input logic [W-1:0] p, input logic s, input logic wr);
    @(posedge clk);
    #1;
    check({tag, ".pat"},  32'(pat),  32'(p));
    check({tag, ".step"}, 32'(step), 32'(s));
    check({tag, ".wrap"}, 32'(wrap), 32'(wr));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0; mode = 2'b00; load = 1'b0; load_val = 4'b0000;

    // rotate right, div=0
    add(1'b1, 1'b0, 8'd0, 2'b00, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b00, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b00, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b00, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b00, 4'b0001, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'd0, 2'b00, 4'b1000, 1'b1, 1'b0);
    // rotate left, div=2, with a 5-cycle freeze
    add(1'b1, 1'b0, 8'd2, 2'b01, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 8'd2, 2'b01, 4'b0010, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0010, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd2, 2'b01, 4'b0100, 1'b1, 1'b0);
    // bounce
    add(1'b1, 1'b0, 8'd0, 2'b10, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b10, 4'b0010, 1'b1, 1'b1);
    // fill
    add(1'b1, 1'b0, 8'd0, 2'b11, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b11, 4'b0011, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b11, 4'b0111, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b11, 4'b1111, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b11, 4'b0001, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'd0, 2'b11, 4'b0011, 1'b1, 1'b0);
    // div=5, reset at cnt=3, first step on 6th enabled cycle
    add(1'b1, 1'b0, 8'd5, 2'b00, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 8'd5, 2'b00, 4'b0001, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'd5, 2'b00, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 8'd5, 2'b00, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'd5, 2'b00, 4'b1000, 1'b1, 1'b0);
    // mode change with coincident tick restarts pos: wrap 4 steps later
    add(1'b0, 1'b1, 8'd0, 2'b01, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b01, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b01, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'd0, 2'b01, 4'b1000, 1'b1, 1'b1);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      div  = vecs[i].div;
      mode = vecs[i].mode;
      tick_and_check($sformatf("vec%0d", i), vecs[i].exp_pat, vecs[i].exp_step, vecs[i].exp_wrap);
    end

    // Reduced div takes effect immediately
    rst = 1'b1; en = 1'b1; div = 8'd5; mode = 2'b00;
    tick_and_check("rdiv.rst", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick_and_check("rdiv.cnt", 4'b0001, 1'b0, 1'b0);
    div = 8'd1;
    tick_and_check("rdiv.now", 4'b1000, 1'b1, 1'b0);
    tick_and_check("rdiv.gap", 4'b1000, 1'b0, 1'b0);
    tick_and_check("rdiv.next", 4'b0100, 1'b1, 1'b0);

`ifdef SHIFT_LOAD_EN
    // Load on the tick cycle discards the tick
    rst = 1'b1; en = 1'b1; div = 8'd2; mode = 2'b00;
    tick_and_check("load.rst", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    tick_and_check("load.c1", 4'b0001, 1'b0, 1'b0);
    tick_and_check("load.c2", 4'b0001, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b1010;
    tick_and_check("load.ld", 4'b1010, 1'b0, 1'b0);
    load = 1'b0;
    tick_and_check("load.w1", 4'b1010, 1'b0, 1'b0);
    tick_and_check("load.w2", 4'b1010, 1'b0, 1'b0);
    tick_and_check("load.step", 4'b0101, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
